register_file: RTL and testbench



---
 rtl/register_file_pkg.sv | 13 +
 rtl/register_file_if.sv | 25 ++
 rtl/register_file_read_port.sv | 40 ++++
 rtl/register_file.sv | 66 ++++++
 tb/tb_register_file.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/register_file_pkg.sv
// Shared constants and types for the 32x32 two-read/one-write register file.
// Optional write-through bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int ZERO_REG = 31;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/register_file_if.sv
// Write/read bus of the register file; slave side is the register file itself.
interface register_file_if #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
);

  logic [ADDR_W-1:0] w_add_i;
  logic [DATA_W-1:0] w_dat_i;
  logic              write_en_i;
  logic [ADDR_W-1:0] a_add_sel;
  logic [ADDR_W-1:0] b_add_sel;
  logic [DATA_W-1:0] r_port_a_o;
  logic [DATA_W-1:0] r_port_b_o;

  modport slave (
    input  w_add_i, w_dat_i, write_en_i, a_add_sel, b_add_sel,
    output r_port_a_o, r_port_b_o
  );

  modport master (
    output w_add_i, w_dat_i, write_en_i, a_add_sel, b_add_sel,
    input  r_port_a_o, r_port_b_o
  );

endinterface

// File: rtl/register_file_read_port.sv
// One combinational read port: entry mux, zero-register force and,
// when REGFILE_BYPASS_EN is defined, same-cycle write-through.
module regfile_read_port #(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
  input  logic [ADDR_W-1:0] i_rd_add,
  input  logic [DATA_W-1:0] i_regs [2**ADDR_W],
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_add,
  input  logic [DATA_W-1:0] i_wr_dat,
  output logic [DATA_W-1:0] o_rd_dat
);

  localparam logic [ADDR_W-1:0] ZERO_ADD = ADDR_W'(ZERO_REG);

  logic w_hit;

`ifdef REGFILE_BYPASS_EN
  // Write-through only for a live, non-zero-register write hitting this address
  assign w_hit = i_rst_n && i_wr_en && (i_wr_add != ZERO_ADD) && (i_wr_add == i_rd_add);
`else
  logic w_unused_bypass;
  assign w_unused_bypass = ^{i_rst_n, i_wr_en, i_wr_add, i_wr_dat};
  assign w_hit           = 1'b0;
`endif

  always_comb begin
    o_rd_dat = i_regs[i_rd_add];
    if (w_hit) begin
      o_rd_dat = i_wr_dat;
    end
    if (i_rd_add == ZERO_ADD) begin
      o_rd_dat = '0;
    end
  end

endmodule

// File: rtl/register_file.sv
// 32x32 register file, two combinational read ports, one synchronous write port,
// register ZERO_REG hard-wired to zero. Optional bypass: REGFILE_BYPASS_EN.
module register_file #(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  register_file_if.slave  rf
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] w_regs [NUM_REGS];

  // The zero register has no storage; every other entry is its own register
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_entry
      if (gi == ZERO_REG) begin : g_zero
        assign w_regs[gi] = '0;
      end else begin : g_store
        logic [DATA_W-1:0] r_entry;

        always_ff @(posedge clk_i or negedge rst_n_i) begin
          if (!rst_n_i) begin
            r_entry <= '0;
          end else if (rf.write_en_i && (rf.w_add_i == ADDR_W'(gi))) begin
            r_entry <= rf.w_dat_i;
          end
        end

        assign w_regs[gi] = r_entry;
      end
    end
  endgenerate

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_port_a (
    .i_rd_add (rf.a_add_sel),
    .i_regs   (w_regs),
    .i_rst_n  (rst_n_i),
    .i_wr_en  (rf.write_en_i),
    .i_wr_add (rf.w_add_i),
    .i_wr_dat (rf.w_dat_i),
    .o_rd_dat (rf.r_port_a_o)
  );

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_port_b (
    .i_rd_add (rf.b_add_sel),
    .i_regs   (w_regs),
    .i_rst_n  (rst_n_i),
    .i_wr_en  (rf.write_en_i),
    .i_wr_add (rf.w_add_i),
    .i_wr_dat (rf.w_dat_i),
    .o_rd_dat (rf.r_port_b_o)
  );

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: driver pushes expected read data from an
// array model, a negedge monitor pops and compares both ports.
module tb_register_file;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rf ();

  register_file #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .rf      (rf)
  );

  typedef struct {
    logic [31:0] ea;
    logic [31:0] eb;
    int          ra;
    int          rb;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [32];
  bit          pend_we;
  int          pend_wa;
  logic [31:0] pend_wd;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Architectural read: zero register, optional write-through, else stored value
  function automatic logic [31:0] expect_rd(int ra);
    if (ra == ZERO_REG) return 32'h0;
    if (BYPASS && rst_n && rf.write_en_i && (int'(rf.w_add_i) != ZERO_REG) && (int'(rf.w_add_i) == ra))
      return rf.w_dat_i;
    return model[ra];
  endfunction

  task automatic step(bit we, int wa, logic [31:0] wd, int ra, int rb, string tag,
                      bit rst_lvl = 1'b1, bit mid_rst = 1'b0);
    @(posedge clk);
    #1;
    if (pend_we && rst_n && pend_wa != ZERO_REG) model[pend_wa] = pend_wd;
    rst_n         = rst_lvl;
    rf.write_en_i = we;
    rf.w_add_i    = wa[4:0];
    rf.w_dat_i    = wd;
    rf.a_add_sel  = ra[4:0];
    rf.b_add_sel  = rb[4:0];
    if (mid_rst) begin
      #1;
      rst_n = 1'b0;
    end
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end
    sb.push_back('{expect_rd(ra), expect_rd(rb), ra, rb, tag});
    pend_we = we;
    pend_wa = wa;
    pend_wd = wd;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      checks++;
      if (rf.r_port_a_o !== cur.ea) begin
        errors++;
        $display("FAIL %s port A R%0d: got %h expected %h", cur.tag, cur.ra, rf.r_port_a_o, cur.ea);
      end
      checks++;
      if (rf.r_port_b_o !== cur.eb) begin
        errors++;
        $display("FAIL %s port B R%0d: got %h expected %h", cur.tag, cur.rb, rf.r_port_b_o, cur.eb);
      end
      $display("txn %-8s A R%0d=%h B R%0d=%h", cur.tag, cur.ra, rf.r_port_a_o, cur.rb, rf.r_port_b_o);
    end
  end

  initial begin
    int wa, ra, rb;
    rst_n         = 1'b0;
    rf.write_en_i = 1'b0;
    rf.w_add_i    = '0;
    rf.w_dat_i    = '0;
    rf.a_add_sel  = '0;
    rf.b_add_sel  = '0;
    pend_we       = 1'b0;
    pend_wa       = 0;
    pend_wd       = 32'h0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Reads under reset, with writes attempted that must be ignored
    for (int i = 0; i < 32; i++)
      step(1'b1, int'($urandom_range(0, 31)), $urandom, i, 31 - i, "reset", 1'b0);
    step(1'b0, 0, 32'h0, 0, 1, "release", 1'b1);

    step(1'b1, 5, 32'hDEADBEEF, 4, 6, "wr5");
    step(1'b0, 0, 32'h0, 5, 5, "rd5");
    step(1'b0, 0, 32'h0, 4, 6, "r4r6");

    step(1'b1, 31, 32'h12345678, 31, 31, "wr31");
    step(1'b0, 0, 32'h0, 31, 31, "rd31");
    step(1'b0, 0, 32'h0, 5, 4, "others");

    step(1'b1, 7, 32'h77777777, 7, 7, "wr7");
    step(1'b0, 7, 32'hFFFFFFFF, 7, 7, "gate7");
    step(1'b0, 0, 32'h0, 7, 7, "rd7");

    step(1'b1, 9, 32'h11111111, 9, 9, "wr9old");
    step(1'b1, 9, 32'hA5A5A5A5, 9, 8, "r9same");
    step(1'b0, 0, 32'h0, 9, 9, "r9after");

    for (int n = 0; n < 400; n++) begin
      wa = int'($urandom_range(0, 31));
      ra = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 31));
      step(1'($urandom_range(0, 1)), wa, $urandom, ra, rb, "random");
    end

    for (int i = 0; i < 31; i++)
      step(1'b1, i, {8'(i + 1), 24'hC0FFEE} ^ 32'(i), i, int'($urandom_range(0, 31)), "fill");
    step(1'b0, 0, 32'h0, 0, 30, "filled");

    // Reset pulled low between edges while a write is pending
    step(1'b1, 3, 32'hCAFEF00D, 3, 10, "midrst", 1'b1, 1'b1);
    for (int i = 0; i < 32; i++)
      step(1'b1, i, $urandom, i, (i + 7) % 32, "inrst", 1'b0);
    step(1'b0, 0, 32'h0, 3, 10, "postrst", 1'b1);
    step(1'b0, 0, 32'h0, 0, 30, "postrst", 1'b1);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
